// File: rtl/conv2d_multich_stream.sv
// Multi-channel KSIZE x KSIZE convolution stage: one kernel tap per cycle across all channels,
// then bias, optional ReLU and saturation at write-out; each pixel is streamed with its coordinates.
module conv2d_multich_stream #(
  parameter int SIZE      = 7,
  parameter int KSIZE     = 3,
  parameter int CHANNELS  = 2,
  parameter int WIDTH_BIT = 8,
  parameter int STRIDE    = 1,
  parameter int RELU_EN   = 1,
  localparam int OUT      = (SIZE - KSIZE) / STRIDE + 1,
  localparam int CW       = $clog2(OUT) + 1
) (
  input  logic                                                  clock,
  input  logic                                                  nreset,
  input  logic                                                  start,
  input  logic [CHANNELS-1:0][SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]   inpMatrix,
  input  logic [CHANNELS-1:0][KSIZE-1:0][KSIZE-1:0][WIDTH_BIT-1:0] Kernel,
  input  logic [WIDTH_BIT-1:0]                                  bias,
  output logic                                                  busy,
  output logic                                                  done,
  output logic                                                  out_valid,
  output logic [CW-1:0]                                         out_row,
  output logic [CW-1:0]                                         out_col,
  output logic [WIDTH_BIT-1:0]                                  out_pixel,
  output logic [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0]                convOut
);

  localparam int ACC_W = 2 * WIDTH_BIT + $clog2(CHANNELS * KSIZE * KSIZE) + 1;
  localparam int KW    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int IW    = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MAC   = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (WIDTH_BIT - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [1:0]                            state_q, state_d;
  logic signed [ACC_W-1:0]               acc_q, acc_d;
  logic [CW-1:0]                         r_q, r_d, c_q, c_d;
  logic [KW-1:0]                         ky_q, ky_d, kx_q, kx_d;
  logic                                  busy_q, busy_d;
  logic                                  done_q, done_d;
  logic                                  out_valid_q, out_valid_d;
  logic [CW-1:0]                         out_row_q, out_row_d;
  logic [CW-1:0]                         out_col_q, out_col_d;
  logic [WIDTH_BIT-1:0]                  out_pixel_q, out_pixel_d;
  logic [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0] conv_q, conv_d;

  logic [IW-1:0]                 iy, ix;
  logic signed [2*WIDTH_BIT-1:0] prod;
  logic signed [ACC_W-1:0]       tap_sum, sum_bias;
  logic [WIDTH_BIT-1:0]          pix_res;

  // One tap of every channel's window, summed across channels.
  always_comb begin
    iy      = IW'(int'(r_q) * STRIDE + int'(ky_q));
    ix      = IW'(int'(c_q) * STRIDE + int'(kx_q));
    prod    = '0;
    tap_sum = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      prod    = $signed(inpMatrix[ch][iy][ix]) * $signed(Kernel[ch][ky_q][kx_q]);
      tap_sum = tap_sum + ACC_W'(prod);
    end
  end

  always_comb begin
    sum_bias = acc_q + ACC_W'($signed(bias));
    if (RELU_EN != 0 && sum_bias < 0)
      pix_res = '0;
    else if (sum_bias > SAT_MAX)
      pix_res = SAT_MAX[WIDTH_BIT-1:0];
    else if (sum_bias < SAT_MIN)
      pix_res = SAT_MIN[WIDTH_BIT-1:0];
    else
      pix_res = sum_bias[WIDTH_BIT-1:0];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    r_d         = r_q;
    c_d         = c_q;
    ky_d        = ky_q;
    kx_d        = kx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = 1'b0;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_pixel_d = out_pixel_q;
    conv_d      = conv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          r_d     = '0;
          c_d     = '0;
          ky_d    = '0;
          kx_d    = '0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + tap_sum;
        if (kx_q == KW'(KSIZE - 1)) begin
          kx_d = '0;
          if (ky_q == KW'(KSIZE - 1)) begin
            ky_d    = '0;
            state_d = WRITE;
          end else begin
            ky_d = ky_q + 1'b1;
          end
        end else begin
          kx_d = kx_q + 1'b1;
        end
      end
      WRITE: begin
        for (int i = 0; i < OUT; i++)
          for (int j = 0; j < OUT; j++)
            if (r_q == CW'(i) && c_q == CW'(j))
              conv_d[i][j] = pix_res;
        out_pixel_d = pix_res;
        out_row_d   = r_q;
        out_col_d   = c_q;
        out_valid_d = 1'b1;
        acc_d       = '0;
        state_d     = MAC;
        if (c_q == CW'(OUT - 1)) begin
          c_d = '0;
          if (r_q == CW'(OUT - 1)) begin
            r_d     = '0;
            state_d = FIN;
          end else begin
            r_d = r_q + 1'b1;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      FIN: begin
        // done and the falling busy share the same cycle, back in IDLE.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      ky_q        <= '0;
      kx_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_pixel_q <= '0;
      conv_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      r_q         <= r_d;
      c_q         <= c_d;
      ky_q        <= ky_d;
      kx_q        <= kx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_pixel_q <= out_pixel_d;
      conv_q      <= conv_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_pixel = out_pixel_q;
  assign convOut   = conv_q;

endmodule

// File: tb/tb_conv2d_multich_stream.sv
// Directed bench for conv2d_multich_stream: four parameterisations (default, no ReLU,
// stride 2, single-channel 3x3) share one clock and reset.
module tb_conv2d_multich_stream;

  logic clock  = 1'b0;
  logic nreset = 1'b0;
  always #5 clock = ~clock;

  logic        start_v [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic        vld_v   [4];
  logic [31:0] orow_v  [4];
  logic [31:0] ocol_v  [4];
  int          outn    [4] = '{5, 5, 3, 1};
  int          checks = 0;
  int          errors = 0;

  logic [1:0][6:0][6:0][7:0] inp0, inp1, inp2;
  logic [1:0][2:0][2:0][7:0] ker0, ker1, ker2;
  logic [0:0][2:0][2:0][7:0] inp3, ker3;
  logic [7:0]                bias0, bias1, bias2, bias3;
  logic [7:0]                pix0, pix1, pix2, pix3;
  logic [3:0]                row0, col0, row1, col1;
  logic [2:0]                row2, col2;
  logic [0:0]                row3, col3;
  logic [4:0][4:0][7:0]      conv0, conv1;
  logic [2:0][2:0][7:0]      conv2;
  logic [0:0][0:0][7:0]      conv3;

  conv2d_multich_stream u_dflt (
    .clock(clock), .nreset(nreset), .start(start_v[0]), .inpMatrix(inp0), .Kernel(ker0),
    .bias(bias0), .busy(busy_v[0]), .done(done_v[0]), .out_valid(vld_v[0]),
    .out_row(row0), .out_col(col0), .out_pixel(pix0), .convOut(conv0));

  conv2d_multich_stream #(.RELU_EN(0)) u_norelu (
    .clock(clock), .nreset(nreset), .start(start_v[1]), .inpMatrix(inp1), .Kernel(ker1),
    .bias(bias1), .busy(busy_v[1]), .done(done_v[1]), .out_valid(vld_v[1]),
    .out_row(row1), .out_col(col1), .out_pixel(pix1), .convOut(conv1));

  conv2d_multich_stream #(.STRIDE(2)) u_stride2 (
    .clock(clock), .nreset(nreset), .start(start_v[2]), .inpMatrix(inp2), .Kernel(ker2),
    .bias(bias2), .busy(busy_v[2]), .done(done_v[2]), .out_valid(vld_v[2]),
    .out_row(row2), .out_col(col2), .out_pixel(pix2), .convOut(conv2));

  conv2d_multich_stream #(.SIZE(3), .KSIZE(3), .CHANNELS(1)) u_k3 (
    .clock(clock), .nreset(nreset), .start(start_v[3]), .inpMatrix(inp3), .Kernel(ker3),
    .bias(bias3), .busy(busy_v[3]), .done(done_v[3]), .out_valid(vld_v[3]),
    .out_row(row3), .out_col(col3), .out_pixel(pix3), .convOut(conv3));

  assign orow_v[0] = 32'(row0);
  assign ocol_v[0] = 32'(col0);
  assign orow_v[1] = 32'(row1);
  assign ocol_v[1] = 32'(col1);
  assign orow_v[2] = 32'(row2);
  assign ocol_v[2] = 32'(col2);
  assign orow_v[3] = 32'(row3);
  assign ocol_v[3] = 32'(col3);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Same 7x7 two-channel stimulus into the default and no-ReLU instances.
  task automatic fill01(input logic [7:0] px, input logic [7:0] tp, input logic [7:0] b);
    for (int ch = 0; ch < 2; ch++) begin
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 7; c++) begin
          inp0[ch][r][c] = px;
          inp1[ch][r][c] = px;
        end
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          ker0[ch][r][c] = tp;
          ker1[ch][r][c] = tp;
        end
    end
    bias0 = b;
    bias1 = b;
  endtask

  function automatic int miss0(input logic [7:0] e);
    int n = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        if (conv0[i][j] !== e) n++;
    return n;
  endfunction

  function automatic int miss1(input logic [7:0] e);
    int n = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        if (conv1[i][j] !== e) n++;
    return n;
  endfunction

  // Pulse start on instance k, then count edges to done; poke >= 0 re-pulses start mid-run.
  task automatic run(input int k, input int budget, input int poke,
                     output int edges, output int nval, output int nerr);
    int  er = 0;
    int  ec = 0;
    bit  got = 1'b0;
    edges = 0;
    nval  = 0;
    nerr  = 0;
    @(negedge clock);
    start_v[k] = 1'b1;
    @(posedge clock);
    #1;
    start_v[k] = 1'b0;
    if (busy_v[k] !== 1'b1) nerr++;
    while (!got && edges < budget) begin
      @(posedge clock);
      edges++;
      #1;
      if (vld_v[k] === 1'b1) begin
        nval++;
        if (orow_v[k] !== 32'(er) || ocol_v[k] !== 32'(ec)) nerr++;
        ec++;
        if (ec == outn[k]) begin
          ec = 0;
          er++;
        end
      end
      if (done_v[k] === 1'b1) got = 1'b1;
      else if (busy_v[k] !== 1'b1) nerr++;
      start_v[k] = (edges == poke);
    end
    start_v[k] = 1'b0;
    chk($sformatf("done_seen_%0d", k), 32'(got), 32'd1);
  endtask

  initial begin
    int edges, nval, nerr, ndone;
    start_v = '{default: 1'b0};
    fill01(8'd0, 8'd0, 8'd0);
    inp2 = '0; ker2 = '0; bias2 = '0;
    inp3 = '0; ker3 = '0; bias3 = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy_v[0]), 0);
    chk("rst_done", 32'(done_v[0]), 0);
    chk("rst_valid", 32'(vld_v[0]), 0);
    chk("rst_rowcol", orow_v[0] | ocol_v[0], 0);
    chk("rst_pixel", 32'(pix0), 0);
    chk("rst_map", 32'(miss0(8'd0)), 0);
    @(negedge clock);
    nreset = 1'b1;

    // All ones, bias 0: 2 channels x 9 taps.
    fill01(8'd1, 8'd1, 8'd0);
    run(0, 400, -1, edges, nval, nerr);
    chk("t1_latency", 32'(edges), 251);
    chk("t1_valid_cnt", 32'(nval), 25);
    chk("t1_order_busy", 32'(nerr), 0);
    chk("t1_busy_at_done", 32'(busy_v[0]), 0);
    chk("t1_map", 32'(miss0(8'd18)), 0);
    chk("t1_corner", 32'(conv0[4][4]), 18);
    chk("t1_last_pixel", 32'(pix0), 18);
    @(posedge clock);
    #1;
    chk("t1_done_pulse", 32'(done_v[0]), 0);

    fill01(8'd127, 8'd127, 8'd127);
    run(0, 400, -1, edges, nval, nerr);
    chk("t2_sat_pos", 32'(miss0(8'd127)), 0);

    fill01(8'd127, 8'h80, 8'd0);
    run(1, 400, -1, edges, nval, nerr);
    chk("t2_sat_neg", 32'(miss1(8'h80)), 0);
    chk("t2_neg_pixel", 32'(pix1), 32'h80);

    // -18 + bias: 20 -> 2, 5 -> -13 (clamped with ReLU, passed without).
    fill01(8'd1, 8'hFF, 8'd20);
    run(0, 400, -1, edges, nval, nerr);
    chk("t3_bias20", 32'(miss0(8'd2)), 0);
    fill01(8'd1, 8'hFF, 8'd5);
    run(0, 400, -1, edges, nval, nerr);
    chk("t3_relu_clamp", 32'(miss0(8'd0)), 0);
    run(1, 400, -1, edges, nval, nerr);
    chk("t3_norelu_neg", 32'(miss1(8'hF3)), 0);

    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        inp2[0][r][c] = 8'(r + c);
    ker2[0][1][1] = 8'd1;
    run(2, 200, -1, edges, nval, nerr);
    chk("t4_latency", 32'(edges), 91);
    chk("t4_valid_cnt", 32'(nval), 9);
    chk("t4_order_busy", 32'(nerr), 0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("t4_map_%0d_%0d", i, j), 32'(conv2[i][j]), 32'(2 * i + 2 * j + 2));

    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        inp3[0][r][c] = 8'(3 * r + c + 1);
    ker3[0][1][1] = 8'd1;
    bias3 = 8'd7;
    run(3, 50, -1, edges, nval, nerr);
    chk("t6_latency", 32'(edges), 11);
    chk("t6_valid_cnt", 32'(nval), 1);
    chk("t6_map", 32'(conv3[0][0]), 12);
    chk("t6_pixel", 32'(pix3), 12);

    // start re-pulsed mid-run must neither restart nor queue.
    fill01(8'd1, 8'd1, 8'd0);
    run(0, 400, 50, edges, nval, nerr);
    chk("t5_no_restart_lat", 32'(edges), 251);
    chk("t5_valid_cnt", 32'(nval), 25);
    ndone = 0;
    repeat (300) begin
      @(posedge clock);
      #1;
      if (done_v[0] === 1'b1) ndone++;
    end
    chk("t5_extra_done", 32'(ndone), 0);
    chk("t5_idle_busy", 32'(busy_v[0]), 0);
    chk("t5_map", 32'(miss0(8'd18)), 0);

    // Asynchronous reset in the middle of a run.
    fill01(8'd2, 8'd1, 8'd0);
    @(negedge clock);
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    repeat (40) @(negedge clock);
    chk("t5_busy_mid", 32'(busy_v[0]), 1);
    #2;
    nreset = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy_v[0]), 0);
    chk("t5_rst_map", 32'(miss0(8'd0)), 0);
    chk("t5_rst_pixel", 32'(pix0), 0);
    @(negedge clock);
    nreset = 1'b1;
    run(0, 400, -1, edges, nval, nerr);
    chk("t5_rerun_lat", 32'(edges), 251);
    chk("t5_rerun_map", 32'(miss0(8'd36)), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
